// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide unit with architectural HI/LO registers
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   start  - op request, accepted when idle and cancel is low
//   op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO (6/7 ignored)
//   rs, rt - operand A (dividend/multiplicand/MTHI-MTLO source), operand B
//   cancel - pipeline flush, aborts a running op without touching HI/LO
//   busy   - op in progress
//   done   - one-cycle pulse after HI/LO are written by MULT*/DIV*
//   hi, lo - HI/LO registers
//
// Define MDU_FAST_MULT_EN to finish MULT/MULTU in one cycle with a full
// 64-bit multiplier; DIV/DIVU keep the iterative path.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] a, b, quo, rem;
    logic [63:0] acc, prod;
    logic [32:0] add_sum, shl, sub_diff;
    logic        is_mul, neg_q, neg_r, signed_op;
`ifdef MDU_FAST_MULT_EN
    logic signed [63:0] s_prod;
    logic [63:0]        u_prod;
`endif
    assign busy = state != IDLE;
    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        signed_op = op == 3'd0 || op == 3'd2;
        add_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a} : 33'd0);
        shl       = {acc[63:32], acc[31]};
        sub_diff  = shl - {1'b0, b};
        prod      = neg_q ? -acc : acc;
        // divide by zero yields all-ones quotient; the remainder path already returns rs
        quo       = b == 32'd0 ? 32'hFFFFFFFF : neg_q ? -acc[31:0] : acc[31:0];
        rem       = neg_r ? -acc[63:32] : acc[63:32];
`ifdef MDU_FAST_MULT_EN
        s_prod    = $signed(rs) * $signed(rt);
        u_prod    = {32'd0, rs} * {32'd0, rt};
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            a      <= 32'd0;
            b      <= 32'd0;
            acc    <= 64'd0;
            is_mul <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start && !cancel) begin
                    if (op == 3'd4) hi <= rs;
                    if (op == 3'd5) lo <= rs;
`ifdef MDU_FAST_MULT_EN
                    if (op == 3'd0 || op == 3'd1) begin
                        {hi, lo} <= signed_op ? s_prod : u_prod;
                        done     <= 1'b1;
                    end
                    if (op == 3'd2 || op == 3'd3) begin
`else
                    if (op < 3'd4) begin
`endif
                        a      <= signed_op && rs[31] ? -rs : rs;
                        b      <= signed_op && rt[31] ? -rt : rt;
                        acc    <= {32'd0, op[1] ? (signed_op && rs[31] ? -rs : rs) : (signed_op && rt[31] ? -rt : rt)};
                        neg_q  <= signed_op && (rs[31] ^ rt[31]);
                        neg_r  <= signed_op && rs[31];
                        is_mul <= !op[1];
                        cnt    <= 5'd0;
                        state  <= op[1] ? DIV : MUL;
                    end
                end
                MUL: if (cancel) state <= IDLE; else begin
                    acc <= {add_sum, acc[31:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                DIV: if (cancel) state <= IDLE; else begin
                    // restoring step: keep the shifted remainder when the trial subtract underflows
                    acc <= sub_diff[32] ? {shl[31:0], acc[30:0], 1'b0} : {sub_diff[31:0], acc[30:0], 1'b1};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: if (cancel) state <= IDLE; else begin
                    hi    <= is_mul ? prod[63:32] : rem;
                    lo    <= is_mul ? prod[31:0] : quo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, cancel = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs = 32'd0, rt = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int checks = 0, failures = 0;

    muldiv_unit dut (.clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rt(rt),
                     .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs = a; rt = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // n = edges already spent after the accept edge
    task automatic finish_op(input int n, input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        chk({tag, "_busy_early"}, busy, 1);
        repeat (32 - n) tick();
        chk({tag, "_busy_last"}, busy, 1);
        tick();
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
        tick();
        chk({tag, "_done_once"}, done, 0);
    endtask

    task automatic no_done(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick();
            seen |= done;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        start_op(3'd5, 32'hDEADBEEF, 32'd0);
        chk("mtlo_lo", lo, 32'hDEADBEEF);
        chk("mtlo_busy", busy, 0);
        chk("mtlo_done", done, 0);

        start_op(3'd6, 32'h11111111, 32'd0);
        chk("rsvd_busy", busy, 0);
        chk("rsvd_lo", lo, 32'hDEADBEEF);

`ifdef MDU_FAST_MULT_EN
        start_op(3'd0, 32'hFFFFFFFE, 32'h3);
        chk("fmult_busy", busy, 0);
        chk("fmult_done", done, 1);
        chk("fmult_hi", hi, 32'hFFFFFFFF);
        chk("fmult_lo", lo, 32'hFFFFFFFA);
        tick();
        chk("fmult_done_once", done, 0);
        start_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("fmultu_busy", busy, 0);
        chk("fmultu_done", done, 1);
        chk("fmultu_hi", hi, 32'hFFFFFFFE);
        chk("fmultu_lo", lo, 32'h00000001);
        tick();
`else
        start_op(3'd0, 32'hFFFFFFFE, 32'h3);
        finish_op(0, "mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
        start_op(3'd1, 32'hFFFFFFFE, 32'h3);
        finish_op(0, "multu", 32'h00000002, 32'hFFFFFFFA);
`endif

        start_op(3'd2, 32'hFFFFFFF9, 32'h2);
        finish_op(0, "div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
        start_op(3'd3, 32'h7, 32'h2);
        finish_op(0, "divu", 32'h1, 32'h3);
        start_op(3'd3, 32'h12345678, 32'h0);
        finish_op(0, "divu_z", 32'h12345678, 32'hFFFFFFFF);
        start_op(3'd2, 32'hFFFFFFF9, 32'h0);
        finish_op(0, "div_z", 32'hFFFFFFF9, 32'hFFFFFFFF);
        start_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        finish_op(0, "div_ovf", 32'h0, 32'h80000000);

        // MTHI issued while busy must be dropped and must not disturb the running divide
        start_op(3'd3, 32'd100, 32'd7);
        repeat (4) tick();
        op = 3'd4; rs = 32'hAAAAAAAA; start = 1'b1;
        tick();
        start = 1'b0;
        finish_op(5, "busy_start", 32'd2, 32'd14);

`ifdef MDU_FAST_MULT_EN
        start_op(3'd3, 32'd9, 32'd3);
`else
        start_op(3'd0, 32'd9, 32'd3);
`endif
        repeat (4) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy", busy, 0);
        chk("cancel_hi", hi, 32'd2);
        chk("cancel_lo", lo, 32'd14);
        no_done("cancel_no_done", 40);
        chk("cancel_hi_late", hi, 32'd2);

        op = 3'd4; rs = 32'h12345678; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        chk("cancel_mthi_hi", hi, 32'd2);
        chk("cancel_mthi_busy", busy, 0);

        start_op(3'd2, 32'd100, 32'd7);
        repeat (8) tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_busy", busy, 0);
        tick();
        rst = 1'b0;
        no_done("arst_no_done", 40);
        chk("arst_lo_late", lo, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
